matmul_pe_ctrl: RTL and testbench
=================================

# matmul_pe_ctrl

Sequencer for the two-PE complex-MAC datapath (`two_pe`) in the matmul engine. It accepts a start command with a reduction length and base address, and issues reads to the operand buffers. It generates the PE `en`/`valid` strobes aligned to buffer read latency, and captures both PE lane results. Results are presented downstream on a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 10, operand buffer address width
- `CNT_W`, 10, width of reduction length `k_len`
- `DRAIN_TIMEOUT`, 16, max DRAIN cycles before watchdog fires (used only with macro)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  command strobe
- `k_len`  in  CNT_W  reduction length, sampled with accepted `start`
- `base_addr`  in  ADDR_W  first operand address, sampled with accepted `start`
- `busy`  out  1  high from the first ISSUE cycle until return to IDLE
- `done`  out  1  one-cycle pulse when the result handshake completes
- `rd_en`  out  1  operand buffer read enable (buffer data returns next cycle)
- `rd_addr`  out  ADDR_W  operand buffer read address
- `pe_en`  out  1  to `two_pe.en`
- `pe_valid`  out  1  to `two_pe.valid`, marks the last MAC of a reduction
- `pe_valid_out_0`, `pe_valid_out_1`  in  1  lane-done pulses from `two_pe`
- `pe_dout_R_0`, `pe_dout_I_0`, `pe_dout_R_1`, `pe_dout_I_1`  in  64  signed PE results
- `res_valid`  out  1  result available
- `res_ready`  in  1  downstream accepts result
- `res_R_0`, `res_I_0`, `res_R_1`, `res_I_1`  out  64  captured signed results
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, DRAIN, RESULT.
- IDLE: `start`=1 with `k_len`≠0 → latch `k_len` and `base_addr`, clear `idx`, `got0`, `got1`, result registers and `timeout_err`; go to ISSUE. `start` with `k_len`=0 is ignored. `start` outside IDLE is ignored.
- ISSUE: `rd_en`=1 and `rd_addr`=`base+idx` (mod 2^ADDR_W, wraps silently), with `idx` incrementing each cycle. After `idx`=`k_len`−1 is issued → DRAIN.
- `pe_en` = `rd_en` delayed 1 cycle. `pe_valid` = (`rd_en` && `idx`==`k_len`−1) delayed 1 cycle. Both are registered and are 0 in IDLE and RESULT, except for the trailing delayed cycle.
- Capture is enabled in ISSUE and DRAIN:
  - `pe_valid_out_0`=1 → `res_R_0`/`res_I_0` ← lane-0 dout, `got0`=1.
  - Same for lane 1.
  - A repeated pulse overwrites the captured value.
  - Pulses in IDLE or RESULT are ignored.
- DRAIN: `got0`&&`got1` → RESULT. A same-cycle final pulse is captured, then the FSM transitions.
- RESULT: `res_valid`=1 and results are held stable. `res_ready`=1 → `done` pulse next cycle, go to IDLE. `res_valid` drops in the same edge.
- Arithmetic: none on data. Results are passed through at full 64-bit width with no clipping or rounding.
- Reset (`rst_n`=0 at an edge), from any state including mid-ISSUE/DRAIN:
  - State → IDLE.
  - All outputs → 0: `busy`, `done`, `rd_en`, `rd_addr`, `pe_en`, `pe_valid`, `res_valid`, all `res_*`, `timeout_err`.
  - `got0`/`got1`/`idx` cleared.

## Timing
- Cycle 0: `start` sampled. Cycles 1..k_len: ISSUE, `rd_en`=1, `busy`=1.
- Cycles 2..k_len+1: `pe_en`=1. Cycle k_len+1: `pe_valid`=1. DRAIN is entered at cycle k_len+1.
- `res_valid` rises the cycle after the later of the two lane captures.
- `done` is asserted the cycle after the `res_valid`&&`res_ready` edge. `busy` falls in that same cycle.
- Minimum turnaround: a new `start` is accepted in the first IDLE cycle, i.e. the cycle `done` is high.

## Configuration
- `MATMUL_CTRL_TIMEOUT_EN` defined: a DRAIN cycle counter starts at 0 on DRAIN entry. When it reaches `DRAIN_TIMEOUT`:
  - `timeout_err` ← 1 (sticky until the next accepted start).
  - FSM → RESULT. Uncaptured lanes read 0.
- Not defined: DRAIN waits indefinitely, no counter logic is generated, and `timeout_err` is tied 0.

## Test plan
- Reset mid-ISSUE (k_len=8, `rst_n` low at cycle 4) → next cycle all outputs 0, state IDLE. A fresh start then runs normally.
- k_len=4, base=0x3FE → `rd_addr` 0x3FE,0x3FF,0x000,0x001 on cycles 1–4; `pe_en` on cycles 2–5; `pe_valid` only on cycle 5.
- Lane 1 pulses before lane 0 (lane1 dout=−5, lane0 dout=0x7FFF_FFFF_FFFF) → `res_valid` one cycle after the lane-0 pulse, with `res_R_1`=−5 and `res_R_0`=0x7FFF_FFFF_FFFF held.
- `res_ready` held low 10 cycles in RESULT → `res_*` stable and `res_valid` stays 1. Asserting `res_ready` → `done` pulse, then IDLE.
- `start` pulsed during ISSUE and `start` with k_len=0 in IDLE → both ignored; no `rd_en`, `busy` unchanged.
- With `MATMUL_CTRL_TIMEOUT_EN` and DRAIN_TIMEOUT=16, only lane 0 responds → `timeout_err`=1 after 16 DRAIN cycles, `res_R_1`=`res_I_1`=0, `res_valid`=1.

Source files
------------

// File: rtl/matmul_pe_ctrl.sv
// Sequencer for the two-PE complex-MAC datapath: issues operand reads, aligns PE strobes, captures lane results.
// Optional DRAIN watchdog is compiled in when MATMUL_CTRL_TIMEOUT_EN is defined.
module matmul_pe_ctrl #(
    parameter int ADDR_W        = 10,
    parameter int CNT_W         = 10,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    k_len,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                pe_en,
    output logic                pe_valid,
    input  logic                pe_valid_out_0,
    input  logic                pe_valid_out_1,
    input  logic signed [63:0]  pe_dout_R_0,
    input  logic signed [63:0]  pe_dout_I_0,
    input  logic signed [63:0]  pe_dout_R_1,
    input  logic signed [63:0]  pe_dout_I_1,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [63:0]  res_R_0,
    output logic signed [63:0]  res_I_0,
    output logic signed [63:0]  res_R_1,
    output logic signed [63:0]  res_I_1,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_RESULT
    } state_t;

    if (DRAIN_TIMEOUT < 1 || ADDR_W < 1 || CNT_W < 1) begin : g_param_check
        $error("matmul_pe_ctrl: ADDR_W, CNT_W and DRAIN_TIMEOUT must all be >= 1");
    end

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    k_q;
    logic [CNT_W-1:0]    idx;
    logic [ADDR_W-1:0]   base_q;
    logic                got0;
    logic                got1;
    logic                accept;
    logic                last_issue;
    logic                capture_en;
    logic                both_got;
    logic                timeout_hit;

    assign accept     = (state == S_IDLE) && start && (k_len != '0);
    assign last_issue = (idx == k_q - CNT_W'(1));
    assign capture_en = (state == S_ISSUE) || (state == S_DRAIN);
    // Include this cycle's pulses so a final capture and the exit share one edge.
    assign both_got   = (got0 || pe_valid_out_0) && (got1 || pe_valid_out_1);

    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        res_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = base_q + ADDR_W'(idx);
                if (last_issue) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (both_got || timeout_hit) begin
                    state_n = S_RESULT;
                end
            end
            S_RESULT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k_q      <= '0;
            base_q   <= '0;
            idx      <= '0;
            got0     <= 1'b0;
            got1     <= 1'b0;
            pe_en    <= 1'b0;
            pe_valid <= 1'b0;
            done     <= 1'b0;
            res_R_0  <= '0;
            res_I_0  <= '0;
            res_R_1  <= '0;
            res_I_1  <= '0;
        end else begin
            state    <= state_n;
            pe_en    <= rd_en;
            pe_valid <= rd_en && last_issue;
            done     <= (state == S_RESULT) && res_ready;
            if (accept) begin
                k_q     <= k_len;
                base_q  <= base_addr;
                idx     <= '0;
                got0    <= 1'b0;
                got1    <= 1'b0;
                res_R_0 <= '0;
                res_I_0 <= '0;
                res_R_1 <= '0;
                res_I_1 <= '0;
            end else begin
                if (state == S_ISSUE && !last_issue) begin
                    idx <= idx + CNT_W'(1);
                end
                if (capture_en && pe_valid_out_0) begin
                    res_R_0 <= pe_dout_R_0;
                    res_I_0 <= pe_dout_I_0;
                    got0    <= 1'b1;
                end
                if (capture_en && pe_valid_out_1) begin
                    res_R_1 <= pe_dout_R_1;
                    res_I_1 <= pe_dout_I_1;
                    got1    <= 1'b1;
                end
            end
        end
    end

`ifdef MATMUL_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [TO_W-1:0] drain_cnt;

    // Counter reads 0 in the first DRAIN cycle, so the watchdog fires at the end of DRAIN cycle DRAIN_TIMEOUT.
    assign timeout_hit = (state == S_DRAIN) && !both_got &&
                         (drain_cnt == TO_W'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + TO_W'(1);
            end else begin
                drain_cnt <= '0;
            end
            if (accept) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_pe_ctrl.sv
// Self-checking bench for matmul_pe_ctrl: table vectors, directed corner sequences and randomized transactions
// checked against a cycle-timeline reference model.
module tb_matmul_pe_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [9:0]         k_len = '0;
    logic [9:0]         base_addr = '0;
    logic               busy, done, rd_en, pe_en, pe_valid, res_valid, timeout_err;
    logic [9:0]         rd_addr;
    logic               pe_valid_out_0 = 1'b0;
    logic               pe_valid_out_1 = 1'b0;
    logic signed [63:0] pe_dout_R_0 = '0, pe_dout_I_0 = '0, pe_dout_R_1 = '0, pe_dout_I_1 = '0;
    logic               res_ready = 1'b0;
    logic signed [63:0] res_R_0, res_I_0, res_R_1, res_I_1;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle lane pulse schedule for the transaction being run (index = cycle relative to start).
    bit          p0v [64];
    bit          p1v [64];
    logic [63:0] d0r [64];
    logic [63:0] d0i [64];
    logic [63:0] d1r [64];
    logic [63:0] d1i [64];

    typedef struct {
        int          k;
        int          base;
        int          p0;
        int          p1;
        int          w;
        int          r;
        logic [63:0] r0, i0, r1, i1;
    } vec_t;

    vec_t tbl [6];

    matmul_pe_ctrl #(.ADDR_W(10), .CNT_W(10), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .base_addr(base_addr),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .pe_en(pe_en), .pe_valid(pe_valid),
        .pe_valid_out_0(pe_valid_out_0), .pe_valid_out_1(pe_valid_out_1),
        .pe_dout_R_0(pe_dout_R_0), .pe_dout_I_0(pe_dout_I_0),
        .pe_dout_R_1(pe_dout_R_1), .pe_dout_I_1(pe_dout_I_1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_R_0(res_R_0), .res_I_0(res_I_0), .res_R_1(res_R_1), .res_I_1(res_I_1),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drive_idle();
        start          = 1'b0;
        k_len          = '0;
        base_addr      = '0;
        pe_valid_out_0 = 1'b0;
        pe_valid_out_1 = 1'b0;
        pe_dout_R_0    = rnd64();
        pe_dout_I_0    = rnd64();
        pe_dout_R_1    = rnd64();
        pe_dout_I_1    = rnd64();
        res_ready      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_pe_en"}, pe_en, 0);
        chk({tag, "_pe_valid"}, pe_valid, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_R_0"}, res_R_0, 0);
        chk({tag, "_res_I_0"}, res_I_0, 0);
        chk({tag, "_res_R_1"}, res_R_1, 0);
        chk({tag, "_res_I_1"}, res_I_1, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic clear_sched();
        for (int c = 0; c < 64; c++) begin
            p0v[c] = 1'b0;
            p1v[c] = 1'b0;
            d0r[c] = rnd64();
            d0i[c] = rnd64();
            d1r[c] = rnd64();
            d1i[c] = rnd64();
        end
    endtask

    // Reference: RESULT begins the cycle after DRAIN has started (cycle k+1) and both lanes have pulsed at least once.
    function automatic int model_res_cycle(input int k);
        int f0 = 1000;
        int f1 = 1000;
        int m;
        for (int c = 63; c >= 1; c--) begin
            if (p0v[c]) f0 = c;
            if (p1v[c]) f1 = c;
        end
        m = k + 1;
        if (f0 > m) m = f0;
        if (f1 > m) m = f1;
        return m + 1;
    endfunction

    // Runs one transaction starting in the current (IDLE) cycle; returns in the cycle where done is high.
    task automatic run_txn(input string tag, input int k, input int base, input int w, input int r);
        logic [63:0] e0r = '0, e0i = '0, e1r = '0, e1i = '0;
        int last = r + w + 1;
        for (int c = 1; c < r; c++) begin
            if (p0v[c]) begin e0r = d0r[c]; e0i = d0i[c]; end
            if (p1v[c]) begin e1r = d1r[c]; e1i = d1i[c]; end
        end
        for (int n = 0; n <= last; n++) begin
            if (n > 0) begin
                chk({tag, "_busy"}, busy, (n <= r + w));
                chk({tag, "_rd_en"}, rd_en, (n <= k));
                chk({tag, "_rd_addr"}, rd_addr, (n <= k) ? ((base + n - 1) & 'h3FF) : 0);
                chk({tag, "_pe_en"}, pe_en, (n >= 2 && n <= k + 1));
                chk({tag, "_pe_valid"}, pe_valid, (n == k + 1));
                chk({tag, "_res_valid"}, res_valid, (n >= r && n <= r + w));
                chk({tag, "_done"}, done, (n == last));
                chk({tag, "_timeout_err"}, timeout_err, 0);
                if (n == 1) begin
                    chk({tag, "_clr_R_0"}, res_R_0, 0);
                    chk({tag, "_clr_I_1"}, res_I_1, 0);
                end
                if (n >= r) begin
                    chk({tag, "_res_R_0"}, res_R_0, e0r);
                    chk({tag, "_res_I_0"}, res_I_0, e0i);
                    chk({tag, "_res_R_1"}, res_R_1, e1r);
                    chk({tag, "_res_I_1"}, res_I_1, e1i);
                end
            end
            if (n == last) begin
                drive_idle();
            end else begin
                start          = (n == 0) || (n >= 2 && $urandom_range(0, 3) == 0);
                k_len          = (n == 0) ? 10'(k) : 10'($urandom_range(0, 20));
                base_addr      = (n == 0) ? 10'(base) : 10'($urandom_range(0, 1023));
                pe_valid_out_0 = p0v[n];
                pe_valid_out_1 = p1v[n];
                pe_dout_R_0    = d0r[n];
                pe_dout_I_0    = d0i[n];
                pe_dout_R_1    = d1r[n];
                pe_dout_I_1    = d1i[n];
                res_ready      = (n == r + w) || (n < r && $urandom_range(0, 1) == 1);
                step();
            end
        end
    endtask

    initial begin
        logic [63:0] mark;
        int k, base, w, r;

        tbl[0] = '{4, 'h3FE, 3, 4, 0, 6, 64'h1111_2222_3333_4444, 64'h5, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1] = '{1, 'h000, 1, 1, 2, 3, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h7FFF_FFFF_FFFF_FFFF};
        tbl[2] = '{3, 'h010, 9, 2, 10, 10, 64'h0000_7FFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 64'h7};
        tbl[3] = '{8, 'h200, 12, 12, 1, 13, 64'hDEAD_0000_BEEF_0000, 64'h1, 64'h2, 64'hCAFE_F00D_0000_0003};
        tbl[4] = '{2, 'h3FF, 5, 3, 0, 6, 64'h3, 64'h4, 64'h5, 64'h6};
        tbl[5] = '{5, 'h155, 2, 2, 1, 7, 64'hFEDC_BA98_7654_3210, 64'h10, 64'h20, 64'h30};

        drive_idle();
        rst_n = 1'b0;
        step(); step(); step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Reset in the middle of ISSUE after a lane has already been captured.
        start = 1'b1; k_len = 10'd8; base_addr = 10'h100;
        step();
        chk("mid_rd_en", rd_en, 1);
        chk("mid_busy", busy, 1);
        chk("mid_rd_addr1", rd_addr, 'h100);
        start = 1'b0;
        step();
        mark = 64'hDEAD_BEEF_0123_4567;
        pe_valid_out_0 = 1'b1; pe_dout_R_0 = mark; pe_dout_I_0 = 64'h1;
        step();
        pe_valid_out_0 = 1'b0;
        chk("mid_capture_R_0", res_R_0, mark);
        chk("mid_rd_addr3", rd_addr, 'h102);
        step();
        chk("mid_rd_addr4", rd_addr, 'h103);
        rst_n = 1'b0;
        step();
        chk_all_zero("rst_mid_issue");
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_en", rd_en, 0);
        chk("post_rst_pe_en", pe_en, 0);

        for (int t = 0; t < 6; t++) begin
            clear_sched();
            p0v[tbl[t].p0] = 1'b1;
            d0r[tbl[t].p0] = tbl[t].r0;
            d0i[tbl[t].p0] = tbl[t].i0;
            p1v[tbl[t].p1] = 1'b1;
            d1r[tbl[t].p1] = tbl[t].r1;
            d1i[tbl[t].p1] = tbl[t].i1;
            run_txn($sformatf("tbl%0d", t), tbl[t].k, tbl[t].base, tbl[t].w, tbl[t].r);
        end

        // start with k_len=0 in IDLE must not launch a transaction.
        step();
        start = 1'b1; k_len = '0; base_addr = 10'h055;
        step();
        start = 1'b0;
        chk("klen0_busy", busy, 0);
        chk("klen0_rd_en", rd_en, 0);
        step();
        chk("klen0_pe_en", pe_en, 0);
        chk("klen0_busy2", busy, 0);

`ifdef MATMUL_CTRL_TIMEOUT_EN
        // Only lane 0 answers: watchdog fires after 16 DRAIN cycles (DRAIN spans cycles 3..18).
        drive_idle();
        start = 1'b1; k_len = 10'd2; base_addr = '0;
        for (int n = 1; n <= 20; n++) begin
            step();
            start = 1'b0;
            pe_valid_out_0 = (n == 2);
            pe_dout_R_0 = (n == 2) ? 64'h0000_0000_0000_0042 : rnd64();
            pe_dout_I_0 = (n == 2) ? 64'hFFFF_FFFF_FFFF_FFF0 : rnd64();
            res_ready = (n == 19);
            if (n == 18) begin
                chk("to_pre_res_valid", res_valid, 0);
                chk("to_pre_err", timeout_err, 0);
            end
            if (n == 19) begin
                chk("to_res_valid", res_valid, 1);
                chk("to_err", timeout_err, 1);
                chk("to_res_R_1", res_R_1, 0);
                chk("to_res_I_1", res_I_1, 0);
                chk("to_res_R_0", res_R_0, 64'h42);
            end
            if (n == 20) begin
                chk("to_done", done, 1);
                chk("to_err_sticky", timeout_err, 1);
            end
        end
        drive_idle();
`endif

        for (int t = 0; t < 20; t++) begin
            clear_sched();
            k    = $urandom_range(1, 12);
            base = $urandom_range(0, 1023);
            w    = $urandom_range(0, 4);
            for (int c = 1; c <= k + 8; c++) begin
                p0v[c] = ($urandom_range(0, 3) == 0);
                p1v[c] = ($urandom_range(0, 3) == 0);
            end
            p0v[$urandom_range(1, k + 8)] = 1'b1;
            p1v[$urandom_range(1, k + 8)] = 1'b1;
            r = model_res_cycle(k);
            run_txn($sformatf("rnd%0d", t), k, base, w, r);
        end

        step();
        chk("final_busy", busy, 0);
        chk("final_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
